// File: rtl/dram_cmd_sched_if.sv
// Request/command bus between the request queue, the scheduler and the DRAM PHY side.
interface dram_cmd_sched_if #(
    parameter int REQ_WIDTH = 60
);
    logic                 req_valid;
    logic [REQ_WIDTH-1:0] req_data;
    logic                 req_ready;
    logic                 cmd_valid;
    logic [2:0]           cmd_code;
    logic [1:0]           cmd_bg;
    logic [1:0]           cmd_bank;
    logic [15:0]          cmd_addr;
    logic                 done;
    logic                 err;

    modport master (
        output req_valid, req_data,
        input  req_ready, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_addr, done, err
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_addr, done, err
    );
endinterface

// File: rtl/dram_cmd_sched.sv
// DDR4 command scheduler: maps one request at a time onto bg/bank/row/column and
// issues ACT/PRE/RD/WR under an open-page policy with per-bank tRAS tracking.
module dram_cmd_sched #(
    parameter int T_RCD     = 24,
    parameter int T_RP      = 24,
    parameter int T_RAS     = 52,
    parameter int T_CL      = 24,
    parameter int T_BURST   = 4,
    parameter int REQ_WIDTH = 60
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dram_cmd_sched_if.slave bus_if
);
    localparam int CNT_W = $clog2(T_RAS + T_RCD + T_RP + T_CL + T_BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_COL, S_WAIT_DATA
    } state_e;

    typedef enum logic [2:0] {
        C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4
    } cmd_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      op_q, op_d;
    logic [15:0]      req_row_q, req_row_d;
    logic [10:0]      col_q, col_d;
    logic [3:0]       bidx_q, bidx_d;          // {bg, bank}

    logic [15:0]      open_q, open_d;
    logic [15:0]      brow_q [16];
    logic [15:0]      brow_d [16];
    logic [CNT_W-1:0] tras_q [16];
    logic [CNT_W-1:0] tras_d [16];

    logic             ready_q, ready_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [2:0]       cmd_code_q, cmd_code_d;
    logic [1:0]       cmd_bg_q, cmd_bg_d;
    logic [1:0]       cmd_bank_q, cmd_bank_d;
    logic [15:0]      cmd_addr_q, cmd_addr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // time field and unmapped address bits carry no meaning for command generation
    logic unused_req;
    assign unused_req = ^{bus_if.req_data[59:48], bus_if.req_data[35:34], bus_if.req_data[2:0]};

    // Next-state, bank bookkeeping and registered command outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        req_row_d   = req_row_q;
        col_d       = col_q;
        bidx_d      = bidx_q;
        open_d      = open_q;
        brow_d      = brow_q;
        for (int unsigned i = 0; i < 16; i++) begin
            tras_d[i] = (tras_q[i] != '0) ? tras_q[i] - 1'b1 : '0;
        end
        ready_d     = ready_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = C_NOP;
        cmd_bg_d    = '0;
        cmd_bank_d  = '0;
        cmd_addr_d  = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus_if.req_valid && ready_q) begin
                    op_d      = bus_if.req_data[47:36];
                    req_row_d = bus_if.req_data[33:18];
                    col_d     = {bus_if.req_data[17:10], bus_if.req_data[5:3]};
                    bidx_d    = {bus_if.req_data[7:6], bus_if.req_data[9:8]};
                    ready_d   = 1'b0;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_q != 12'd0 && op_q != 12'd1 && op_q != 12'd2) begin
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else if (open_q[bidx_q] && brow_q[bidx_q] == req_row_q) begin
                    state_d = S_COL;
                end else if (open_q[bidx_q]) begin
                    state_d = S_PRE;
                end else begin
                    state_d = S_ACT;
                end
            end
            S_PRE: begin
                if (tras_q[bidx_q] == '0) begin
                    cmd_valid_d    = 1'b1;
                    cmd_code_d     = C_PRE;
                    cmd_bg_d       = bidx_q[3:2];
                    cmd_bank_d     = bidx_q[1:0];
                    open_d[bidx_q] = 1'b0;
                    cnt_d          = CNT_W'(T_RP - 2);
                    state_d        = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                if (cnt_q == '0) state_d = S_ACT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ACT: begin
                cmd_valid_d    = 1'b1;
                cmd_code_d     = C_ACT;
                cmd_bg_d       = bidx_q[3:2];
                cmd_bank_d     = bidx_q[1:0];
                cmd_addr_d     = req_row_q;
                open_d[bidx_q] = 1'b1;
                brow_d[bidx_q] = req_row_q;
                tras_d[bidx_q] = CNT_W'(T_RAS - 1);
                cnt_d          = CNT_W'(T_RCD - 2);
                state_d        = S_WAIT_RCD;
            end
            S_WAIT_RCD: begin
                if (cnt_q == '0) state_d = S_COL;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_COL: begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = (op_q == 12'd1) ? C_WR : C_RD;
                cmd_bg_d    = bidx_q[3:2];
                cmd_bank_d  = bidx_q[1:0];
                cmd_addr_d  = {5'b0, col_q};
                cnt_d       = CNT_W'(T_CL + T_BURST - 1);
                state_d     = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, bank table and output registers; reset closes every bank
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            req_row_q   <= '0;
            col_q       <= '0;
            bidx_q      <= '0;
            open_q      <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                brow_q[i] <= '0;
                tras_q[i] <= '0;
            end
            ready_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            cmd_bg_q    <= '0;
            cmd_bank_q  <= '0;
            cmd_addr_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            req_row_q   <= req_row_d;
            col_q       <= col_d;
            bidx_q      <= bidx_d;
            open_q      <= open_d;
            brow_q      <= brow_d;
            tras_q      <= tras_d;
            ready_q     <= ready_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_bg_q    <= cmd_bg_d;
            cmd_bank_q  <= cmd_bank_d;
            cmd_addr_q  <= cmd_addr_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus_if.req_ready = ready_q;
    assign bus_if.cmd_valid = cmd_valid_q;
    assign bus_if.cmd_code  = cmd_code_q;
    assign bus_if.cmd_bg    = cmd_bg_q;
    assign bus_if.cmd_bank  = cmd_bank_q;
    assign bus_if.cmd_addr  = cmd_addr_q;
    assign bus_if.done      = done_q;
    assign bus_if.err       = err_q;
endmodule

// File: tb/tb_dram_cmd_sched.sv
// Bench for dram_cmd_sched: directed vector table, reset sequences and random traffic
// checked cycle by cycle against a timestamp-based bank model.
module tb_dram_cmd_sched;
    localparam int T_RCD = 24, T_RP = 24, T_RAS = 52, T_CL = 24, T_BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_cmd_sched_if #(.REQ_WIDTH(60)) bus ();

    dram_cmd_sched #(
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_CL(T_CL), .T_BURST(T_BURST), .REQ_WIDTH(60)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    int n_pass = 0, n_total = 0, cyc = 0;

    // model: per-bank open/row and edge of the last ACT; expected events keyed by edge number
    bit          m_open [16];
    logic [15:0] m_row  [16];
    int          m_act  [16];
    bit          m_ready, m_boot, accepted;
    logic [22:0] exp_cmd  [int];
    bit          exp_done [int];
    bit          exp_err  [int];
    bit          exp_free [int];

    // observations of the request currently being tracked
    int          obs_acc, obs_first, obs_end;
    bit          obs_end_err, obs_saw_col;
    logic [15:0] obs_col_addr;

    typedef struct {
        logic [11:0] op;
        logic [35:0] addr;
        int          first_code;
        logic [15:0] col_addr;
        int          end_off;
        bit          end_err;
    } vec_t;
    vec_t vecs [8];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic model_accept(int e, logic [59:0] d);
        logic [11:0] op;
        logic [15:0] row;
        logic [1:0]  bg, bk;
        logic [10:0] col;
        int b, p, a, t;
        op  = d[47:36];
        row = d[33:18];
        bk  = d[9:8];
        bg  = d[7:6];
        col = {d[17:10], d[5:3]};
        b   = int'(bg) * 4 + int'(bk);
        if (op > 12'd2) begin
            exp_err[e + 1]  = 1'b1;
            exp_free[e + 1] = 1'b1;
            return;
        end
        if (m_open[b] && m_row[b] == row) begin
            t = e + 2;
        end else begin
            if (m_open[b]) begin
                p = (e + 2 > m_act[b] + T_RAS) ? e + 2 : m_act[b] + T_RAS;
                exp_cmd[p] = {3'd4, bg, bk, 16'h0000};
                a = p + T_RP;
            end else begin
                a = e + 2;
            end
            exp_cmd[a] = {3'd1, bg, bk, row};
            m_open[b]  = 1'b1;
            m_row[b]   = row;
            m_act[b]   = a;
            t = a + T_RCD;
        end
        exp_cmd[t] = {(op == 12'd1) ? 3'd3 : 3'd2, bg, bk, {5'b0, col}};
        exp_done[t + T_CL + T_BURST] = 1'b1;
        exp_free[t + T_CL + T_BURST] = 1'b1;
    endtask

    task automatic model_reset();
        exp_cmd.delete();
        exp_done.delete();
        exp_err.delete();
        exp_free.delete();
        for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
        m_ready = 1'b0;
        m_boot  = 1'b1;
    endtask

    // one clock: advance the model, then compare every output 1 ns after the edge
    task automatic step();
        bit          pre_acc;
        logic [59:0] pre_d;
        logic [22:0] cm;
        pre_acc = bus.req_valid && m_ready && !rst;
        pre_d   = bus.req_data;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            if (m_boot) begin
                m_ready = 1'b1;
                m_boot  = 1'b0;
            end
            if (pre_acc) begin
                model_accept(cyc, pre_d);
                m_ready      = 1'b0;
                accepted     = 1'b1;
                obs_acc      = cyc;
                obs_first    = -1;
                obs_end      = -1;
                obs_end_err  = 1'b0;
                obs_saw_col  = 1'b0;
                obs_col_addr = '0;
            end
            if (exp_free.exists(cyc)) m_ready = 1'b1;
        end
        #1;
        cm = exp_cmd.exists(cyc) ? exp_cmd[cyc] : 23'h0;
        check("cycle_outputs",
              {bus.req_ready, bus.cmd_valid, bus.cmd_code, bus.cmd_bg, bus.cmd_bank,
               bus.cmd_addr, bus.done, bus.err},
              {m_ready, exp_cmd.exists(cyc) != 0, cm, exp_done.exists(cyc) != 0,
               exp_err.exists(cyc) != 0});
        if (bus.cmd_valid) begin
            if (obs_first < 0) obs_first = int'(bus.cmd_code);
            if (bus.cmd_code == 3'd2 || bus.cmd_code == 3'd3) begin
                obs_saw_col  = 1'b1;
                obs_col_addr = bus.cmd_addr;
            end
        end
        if ((bus.done || bus.err) && obs_end < 0) begin
            obs_end     = cyc;
            obs_end_err = bus.err;
        end
    endtask

    task automatic run_req(logic [11:0] op, logic [35:0] addr);
        bus.req_valid = 1'b1;
        bus.req_data  = {12'($urandom), op, addr};
        accepted = 1'b0;
        for (int i = 0; i < 300 && !accepted; i++) step();
        if (!accepted) begin
            n_total++;
            $display("FAIL accept_timeout cycle %0d: got no accept expected accept", cyc);
        end
        bus.req_valid = 1'b0;
        bus.req_data  = 60'({$urandom(), $urandom()});
    endtask

    task automatic wait_end();
        for (int i = 0; i < 300 && obs_end < 0; i++) step();
        if (obs_end < 0) begin
            n_total++;
            $display("FAIL end_timeout cycle %0d: got no done/err expected one", cyc);
        end
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        #1 check("reset_async",
                 {bus.req_ready, bus.cmd_valid, bus.cmd_code, bus.cmd_bg, bus.cmd_bank,
                  bus.cmd_addr, bus.done, bus.err}, 64'h0);
        model_reset();
        step();
        step();
        @(negedge clk) rst = 1'b0;
        step();
        check("ready_after_reset", bus.req_ready, 64'h1);
    endtask

    initial begin
        logic [11:0] rop;
        logic [35:0] raddr;

        vecs[0] = '{12'd0,     36'h000040E68, 1,  16'h001D, 54, 1'b0}; // miss
        vecs[1] = '{12'd1,     36'h000040E68, 3,  16'h001D, 30, 1'b0}; // hit write
        vecs[2] = '{12'd0,     36'h000080E68, 4,  16'h001D, 78, 1'b0}; // row conflict
        vecs[3] = '{12'd7,     36'h000080E68, -1, 16'h0000, 1,  1'b1}; // bad op
        vecs[4] = '{12'd2,     36'h000080E68, 2,  16'h001D, 30, 1'b0}; // ifetch hit
        vecs[5] = '{12'd0,     36'h000000000, 1,  16'h0000, 54, 1'b0}; // other bank miss
        vecs[6] = '{12'd1,     36'hC00000007, 3,  16'h0000, 30, 1'b0}; // ignored bits
        vecs[7] = '{12'h100,   36'h000000000, -1, 16'h0000, 1,  1'b1}; // high op bits

        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        obs_first = -1;
        obs_end   = -1;
        obs_acc   = 0;
        model_reset();
        for (int i = 0; i < 3; i++) step();
        @(negedge clk) rst = 1'b0;
        step();
        check("ready_after_reset", bus.req_ready, 64'h1);

        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i].op, vecs[i].addr);
            wait_end();
            check("first_cmd", 64'(obs_first), 64'(vecs[i].first_code));
            if (!vecs[i].end_err) check("col_addr", obs_col_addr, vecs[i].col_addr);
            check("end_offset", 64'(obs_end - obs_acc), 64'(vecs[i].end_off));
            check("end_kind", obs_end_err, vecs[i].end_err);
        end

        // reset while waiting out tRCD: the read must never appear, and the bank must reopen
        run_req(12'd0, 36'h0001403C0);
        for (int i = 0; i < 10; i++) step();
        check("act_before_reset", 64'(obs_first), 64'd1);
        apply_reset();
        for (int i = 0; i < 40; i++) step();
        check("no_col_after_reset", obs_saw_col, 64'h0);
        check("no_done_after_reset", 64'(obs_end), 64'hFFFF_FFFF_FFFF_FFFF);
        run_req(12'd0, 36'h0001403C0);
        wait_end();
        check("reissue_is_miss", 64'(obs_first), 64'd1);
        check("reissue_end", 64'(obs_end - obs_acc), 64'd54);

        for (int n = 0; n < 40; n++) begin
            rop   = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(3, 4095))
                                                 : 12'($urandom_range(0, 2));
            raddr = {2'($urandom), 16'($urandom_range(0, 3)), 8'($urandom),
                     2'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
                     3'($urandom), 3'($urandom)};
            run_req(rop, raddr);
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
        end
        for (int i = 0; i < 120; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
